bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
Shares the single-port byte-wide BRAM between two requesters.
- Port 0: UART command processor (host read/write sweeps).
- Port 1: gate-test engine (pattern fetch / result store).
Issues at most one BRAM access per cycle, routes read-data-valid back to the issuing port, and lets a port lock the BRAM for an uninterrupted sweep, with a watchdog that forces release of an idle lock.

Parameters:
ADDR_W, 16, BRAM address width
DATA_W, 8, BRAM data width
RD_LATENCY, 1, cycles from address sampled by BRAM to valid bram_byte_read (1..4)
LOCK_TIMEOUT, 1024, idle cycles allowed while locked before forced release

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req0/req1  in  1  access request, held until granted
we0/we1  in  1  1=write, 0=read
lock0/lock1  in  1  keep ownership after this access
addr0/addr1  in  ADDR_W  access address
wdata0/wdata1  in  DATA_W  write data
gnt0/gnt1  out  1  one-cycle pulse: access issued this cycle
rvalid0/rvalid1  out  1  one-cycle pulse: rdata valid for this port
rdata  out  DATA_W  bram_byte_read passthrough, shared by both ports
bram_mode  out  1  1=write strobe to BRAM
bram_address  out  ADDR_W  BRAM address
bram_byte_write  out  DATA_W  BRAM write data
bram_byte_read  in  DATA_W  BRAM read data
lock_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async, any time):
  - gnt*, rvalid*, bram_mode, lock_err = 0; bram_address, bram_byte_write = 0.
  - State = IDLE, round-robin pointer favours port 0, watchdog = 0.
  - In-flight rvalid pipeline flushed; no rvalid after reset release.
- Issue timing: req_i sampled at edge E, arbiter picks port i → in the cycle after E:
  - gnt_i=1, bram_address=addr_i, bram_mode=we_i, bram_byte_write=wdata_i (all registered).
- Cycles without a grant:
  - bram_mode=0 (never a stray write).
  - bram_address and bram_byte_write hold their last values.
- Request hold: requester keeps req/we/addr/wdata/lock stable until it observes gnt_i=1.
  - A req_i sampled in a cycle where gnt_i=1 is ignored (no double issue).
  - Max one grant per port every 2 cycles; alternating ports can reach 1 grant/cycle.
- Read data: for a read granted in cycle G, rvalid_i=1 in cycle G+RD_LATENCY with rdata valid.
  - Writes produce no rvalid.
  - Shift-register tag pipeline, depth RD_LATENCY, carries {valid, port}.
- State IDLE:
  - One eligible request → grant it.
  - Both eligible → grant the port not granted last (pointer toggles on each grant).
  - If granted with lock_i=1 → go to OWN_i.
- State OWN_i:
  - Only port i is eligible; the other port's req is held off, never dropped.
  - lock_i=0 sampled on a granted access → that access issues, then return to IDLE.
  - Requester may also release by presenting lock_i=0 with req_i=0 → IDLE next cycle.
- Watchdog (OWN_i only):
  - Counts cycles with req_i=0 and lock_i=1; clears on any req_i.
  - Reaches LOCK_TIMEOUT → IDLE and lock_err pulses for one cycle.
  - req_i in the same cycle the count would reach the limit → request served, counter cleared, no lock_err.
- Width rules: addresses pass through unmodified; no arithmetic on data. Watchdog counter is clog2(LOCK_TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package bram_arb_pkg:
  - state enum {IDLE, OWN0, OWN1}
  - port-id type (1 bit)
  - ADDR_W/DATA_W defaults
  - READ/WRITE mode constants (0/1)
- One sub-module: bram_arb_rvalid_pipe. Parameterised RD_LATENCY shift register of {valid, port} with async reset, producing rvalid0/rvalid1.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x0010 at E → gnt0 next cycle, bram_address=0x0010, bram_mode=0; rvalid0 exactly RD_LATENCY cycles later, rdata = BRAM[0x0010]; rvalid1 never asserts.
- Contention after reset: req0 and req1 raised in the same cycle (writes 0xA5 @0x0100, 0x5A @0x0200) → port 0 granted first, port 1 next eligible cycle; BRAM holds both values; bram_mode=1 only in the two grant cycles.
- Lock sweep: port 0 reads 0x0000–0x0007 with lock0=1 (lock0=0 on last), port 1 requesting throughout → eight gnt0 before any gnt1; gnt1 follows within 2 cycles of the last gnt0.
- Watchdog: LOCK_TIMEOUT=8; port 1 locks then idles with lock1=1 while req0=1 → lock_err pulses once after 8 idle cycles, gnt0 issued the following cycle; repeat with req1 on cycle 8 → no lock_err.
- Back-to-back hold: req1 held high for 10 cycles with changing addr → gnt1 every other cycle, no address issued twice, rvalid1 count = gnt1 count (RD_LATENCY=3).
- Reset mid-operation: assert rst one cycle after a read grant → all outputs 0 immediately (async); after release no rvalid appears, and the next simultaneous request grants port 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and constants for the two-port BRAM arbiter
package bram_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    typedef logic port_t;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_WRITE = 1'b1;
endpackage

// File: rtl/bram_arb_rvalid_pipe.sv
// bram_arb_rvalid_pipe: {valid, port} tag shift register aligning read-data-valid with BRAM latency
module bram_arb_rvalid_pipe
    import bram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  issue,
    input  port_t port,
    output logic  rvalid0,
    output logic  rvalid1
);
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            tag_port <= '0;
        end else begin
            tag_vld[0] <= issue;
            tag_port[0] <= port;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_port[k] <= tag_port[k-1];
            end
        end
    end

    assign rvalid0 = tag_vld[RD_LATENCY-1] & ~tag_port[RD_LATENCY-1];
    assign rvalid1 = tag_vld[RD_LATENCY-1] & tag_port[RD_LATENCY-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of a single-port byte BRAM between two requesters,
// with per-port lock ownership and a watchdog that releases an idle lock.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LATENCY   = 1,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_mode,
    output logic [ADDR_W-1:0] bram_address,
    output logic [DATA_W-1:0] bram_byte_write,
    input  logic [DATA_W-1:0] bram_byte_read,
    output logic              lock_err
);
    localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);

    state_t          state;
    port_t           rr;
    logic [WD_W-1:0] wd;
    logic            elig0, elig1, pick0, pick1, own, own_req, own_lock;

    // A port whose grant is showing this cycle is still holding its old request, so mask it.
    always_comb begin
        elig0 = req0 & ~gnt0 & (state != OWN1);
        elig1 = req1 & ~gnt1 & (state != OWN0);
        pick0 = elig0 & (~elig1 | (rr == 1'b0));
        pick1 = elig1 & ~pick0;
        own = state != IDLE;
        own_req = state == OWN1 ? req1 : req0;
        own_lock = state == OWN1 ? lock1 : lock0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr <= 1'b0;
            wd <= '0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            bram_mode <= MODE_READ;
            bram_address <= '0;
            bram_byte_write <= '0;
            lock_err <= 1'b0;
        end else begin
            gnt0 <= pick0;
            gnt1 <= pick1;
            bram_mode <= pick0 ? we0 : pick1 ? we1 : MODE_READ;
            lock_err <= 1'b0;
            if (pick0 | pick1) begin
                bram_address <= pick0 ? addr0 : addr1;
                bram_byte_write <= pick0 ? wdata0 : wdata1;
                rr <= pick0;
                wd <= '0;
                state <= (pick0 & lock0) ? OWN0 : (pick1 & lock1) ? OWN1 : IDLE;
            end else if (own & ~own_req) begin
                if (~own_lock) begin
                    state <= IDLE;
                    wd <= '0;
                end else if (wd == WD_W'(LOCK_TIMEOUT - 1)) begin
                    state <= IDLE;
                    wd <= '0;
                    lock_err <= 1'b1;
                end else begin
                    wd <= wd + 1'b1;
                end
            end else begin
                wd <= '0;
            end
        end
    end

    bram_arb_rvalid_pipe #(.RD_LATENCY(RD_LATENCY)) u_rvalid_pipe (
        .clk(clk),
        .rst(rst),
        .issue((gnt0 | gnt1) & (bram_mode == MODE_READ)),
        .port(gnt1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1)
    );

    assign rdata = bram_byte_read;
endmodule
